// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: drains an 8-bit FIFO one byte at a time onto an asynchronous serial line.
// Frame format: start bit (0), 8 data bits LSB first, optional parity bit, 1 or 2 stop bits (1).
// All outputs come straight from flops. Each output flop is loaded from the decode of the
// next-state values, so the outputs line up cycle-for-cycle with the state register.
module fifo_serial_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned RD_LATENCY   = 1,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_enable,
  input  logic       i_f_empty_n,
  input  logic [7:0] i_fifo_data,
  output logic       o_read,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_tx_done
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BaudW-1:0] BaudMax = BaudW'(CLKS_PER_BIT - 1);
  // Last WAIT cycle index; RD_LATENCY is at most 3, so 2 bits suffice.
  localparam logic [1:0] WaitLast = 2'(RD_LATENCY - 1);
  // The bit counter is idle during STOP, so it also counts the stop bits.
  localparam logic [2:0] StopLast = 3'(STOP_BITS - 1);
  localparam logic       ParEn    = (PARITY_EN != 0);
  localparam logic       ParOdd   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic [BaudW-1:0]  r_baud;
  logic [BaudW-1:0]  w_baud_d;
  logic [2:0]        r_bit;
  logic [2:0]        w_bit_d;
  logic [1:0]        r_wait;
  logic [1:0]        w_wait_d;
  logic [7:0]        r_shift;
  logic [7:0]        w_shift_d;
  logic              r_parity;
  logic              w_parity_d;

  logic              r_tx;
  logic              w_tx_d;
  logic              r_read;
  logic              w_read_d;
  logic              r_busy;
  logic              w_busy_d;
  logic              r_tx_done;
  logic              w_tx_done_d;

  logic              w_tick;
  logic              w_start_ok;
  logic              w_timed;

  assign w_tick     = (r_baud == BaudMax);
  assign w_start_ok = i_enable & i_f_empty_n;

  // Next-state logic: FSM transitions, baud/bit/wait counters, shift register and parity latch.
  always_comb begin
    w_state_d  = r_state;
    w_bit_d    = r_bit;
    w_wait_d   = '0;
    w_shift_d  = r_shift;
    w_parity_d = r_parity;
    w_timed    = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_start_ok) begin
          w_state_d = StFetch;
        end
      end

      StFetch: begin
        w_state_d = StWait;
      end

      StWait: begin
        if (r_wait == WaitLast) begin
          // FIFO data is valid now; latch it and precompute parity from the whole byte.
          w_state_d  = StStart;
          w_shift_d  = i_fifo_data;
          w_parity_d = (^i_fifo_data) ^ ParOdd;
        end else begin
          w_wait_d = r_wait + 2'd1;
        end
      end

      StStart: begin
        w_timed = 1'b1;
        if (w_tick) begin
          w_state_d = StData;
        end
      end

      StData: begin
        w_timed = 1'b1;
        if (w_tick) begin
          w_shift_d = {1'b0, r_shift[7:1]};
          w_bit_d   = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            w_state_d = ParEn ? StParity : StStop;
          end
        end
      end

      StParity: begin
        w_timed = 1'b1;
        if (w_tick) begin
          w_state_d = StStop;
        end
      end

      StStop: begin
        w_timed = 1'b1;
        if (w_tick) begin
          if (r_bit == StopLast) begin
            w_bit_d   = '0;
            // Back-to-back frames: pop again right away when allowed and data is waiting.
            w_state_d = w_start_ok ? StFetch : StIdle;
          end else begin
            w_bit_d = r_bit + 3'd1;
          end
        end
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase

    // Baud counter runs only in bit-timed states and restarts at every state change.
    if (!w_timed || w_tick || (w_state_d != r_state)) begin
      w_baud_d = '0;
    end else begin
      w_baud_d = r_baud + BaudW'(1);
    end
  end

  // Output decode from next-state values so the registered outputs track the registered state.
  always_comb begin
    w_tx_d = 1'b1;
    unique case (w_state_d)
      StStart:  w_tx_d = 1'b0;
      StData:   w_tx_d = w_shift_d[0];
      StParity: w_tx_d = w_parity_d;
      default:  w_tx_d = 1'b1;
    endcase
    w_read_d    = (w_state_d == StFetch);
    w_busy_d    = (w_state_d != StIdle);
    w_tx_done_d = (w_state_d == StStop) && (w_baud_d == BaudMax) && (w_bit_d == StopLast);
  end

  // State, counters and datapath registers; reset abandons any frame in progress.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= StIdle;
      r_baud   <= '0;
      r_bit    <= '0;
      r_wait   <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_baud   <= w_baud_d;
      r_bit    <= w_bit_d;
      r_wait   <= w_wait_d;
      r_shift  <= w_shift_d;
      r_parity <= w_parity_d;
    end
  end

  // Output flops; TX idles high.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tx      <= 1'b1;
      r_read    <= 1'b0;
      r_busy    <= 1'b0;
      r_tx_done <= 1'b0;
    end else begin
      r_tx      <= w_tx_d;
      r_read    <= w_read_d;
      r_busy    <= w_busy_d;
      r_tx_done <= w_tx_done_d;
    end
  end

  assign o_tx      = r_tx;
  assign o_read    = r_read;
  assign o_busy    = r_busy;
  assign o_tx_done = r_tx_done;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: four instances (plain, even parity, odd parity, 3-cycle read
// latency with 2 stop bits), each fed by a small FIFO model. Bytes pushed into a FIFO are
// also pushed into that instance's expected queue; a per-instance monitor decodes each frame
// off TX and checks it against the queue.
module tb_fifo_serial_tx;

  localparam int NI  = 4;
  localparam int Cpb = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [3:0] ne;
  logic [3:0] rd_w;
  logic [3:0] tx_w;
  logic [3:0] busy_w;
  logic [3:0] done_w;
  logic [7:0] dout [NI] = '{default: 8'h00};
  logic [7:0] mem [NI][16];
  int         wp [NI] = '{default: 0};
  int         rp [NI] = '{default: 0};
  int         rd_count [NI] = '{default: 0};
  int         rd_cyc [NI] = '{default: 0};
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exq0 [$];
  logic [7:0] exq1 [$];
  logic [7:0] exq2 [$];
  logic [7:0] exq3 [$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    ne = '0;
    for (int g = 0; g < NI; g++) ne[g] = (wp[g] != rp[g]);
  end

  // FIFO model: one-cycle read latency, DATA_OUT holds until the next pop.
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (rd_w[g] && ne[g]) begin
        dout[g] <= mem[g][rp[g] % 16];
        rp[g]   <= rp[g] + 1;
      end
      if (rd_w[g]) begin
        rd_count[g] <= rd_count[g] + 1;
        rd_cyc[g]   <= cyc;
      end
    end
  end

  fifo_serial_tx #(.CLKS_PER_BIT(4), .RD_LATENCY(1), .PARITY_EN(0), .PARITY_ODD(0),
                   .STOP_BITS(1)) u_dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_enable(enable), .i_f_empty_n(ne[0]),
    .i_fifo_data(dout[0]), .o_read(rd_w[0]), .o_tx(tx_w[0]), .o_busy(busy_w[0]),
    .o_tx_done(done_w[0]));

  fifo_serial_tx #(.CLKS_PER_BIT(4), .RD_LATENCY(1), .PARITY_EN(1), .PARITY_ODD(0),
                   .STOP_BITS(1)) u_dut_even (
    .i_clock(clk), .i_reset_n(rst_n), .i_enable(enable), .i_f_empty_n(ne[1]),
    .i_fifo_data(dout[1]), .o_read(rd_w[1]), .o_tx(tx_w[1]), .o_busy(busy_w[1]),
    .o_tx_done(done_w[1]));

  fifo_serial_tx #(.CLKS_PER_BIT(4), .RD_LATENCY(1), .PARITY_EN(1), .PARITY_ODD(1),
                   .STOP_BITS(1)) u_dut_odd (
    .i_clock(clk), .i_reset_n(rst_n), .i_enable(enable), .i_f_empty_n(ne[2]),
    .i_fifo_data(dout[2]), .o_read(rd_w[2]), .o_tx(tx_w[2]), .o_busy(busy_w[2]),
    .o_tx_done(done_w[2]));

  fifo_serial_tx #(.CLKS_PER_BIT(4), .RD_LATENCY(3), .PARITY_EN(0), .PARITY_ODD(0),
                   .STOP_BITS(2)) u_dut_lat3 (
    .i_clock(clk), .i_reset_n(rst_n), .i_enable(enable), .i_f_empty_n(ne[3]),
    .i_fifo_data(dout[3]), .o_read(rd_w[3]), .o_tx(tx_w[3]), .o_busy(busy_w[3]),
    .o_tx_done(done_w[3]));

  function automatic int p_lat(input int k);
    return (k == 3) ? 3 : 1;
  endfunction

  function automatic int p_pen(input int k);
    return (k == 1 || k == 2) ? 1 : 0;
  endfunction

  function automatic logic p_podd(input int k);
    return (k == 2);
  endfunction

  function automatic int p_stop(input int k);
    return (k == 3) ? 2 : 1;
  endfunction

  task automatic check(input string name, input int k, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s [dut %0d] at cycle %0d: got 0x%0h, expected 0x%0h",
               name, k, cyc, got, exp);
    end
  endtask

  function automatic int exp_size(input int k);
    case (k)
      0:       return exq0.size();
      1:       return exq1.size();
      2:       return exq2.size();
      default: return exq3.size();
    endcase
  endfunction

  task automatic exp_pop(input int k, output logic [7:0] b);
    case (k)
      0:       b = exq0.pop_front();
      1:       b = exq1.pop_front();
      2:       b = exq2.pop_front();
      default: b = exq3.pop_front();
    endcase
  endtask

  // Load a byte into instance k's FIFO and record it as an expected frame.
  task automatic push(input int k, input logic [7:0] b);
    mem[k][wp[k] % 16] = b;
    wp[k] = wp[k] + 1;
    case (k)
      0:       exq0.push_back(b);
      1:       exq1.push_back(b);
      2:       exq2.push_back(b);
      default: exq3.push_back(b);
    endcase
  endtask

  // Frame monitor: detects a start bit, samples every cycle of the frame, then compares.
  task automatic monitor(input int k);
    int         nb;
    int         start;
    int         done_cyc;
    int         glitch;
    int         ndone;
    int         done_pos;
    int         nbusy;
    bit         b2b;
    bit         abort;
    logic [7:0] b;
    logic [15:0] exp_v;
    logic [15:0] got_v;
    b2b      = 1'b0;
    done_cyc = 0;
    nb       = 1 + 8 + p_pen(k) + p_stop(k);
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        b2b = 1'b0;
      end else if (tx_w[k] == 1'b0) begin
        start = cyc;
        if (exp_size(k) == 0) begin
          check("unexpected_frame", k, 64'd1, 64'd0);
          b = 8'h00;
        end else begin
          exp_pop(k, b);
        end
        exp_v    = '1;
        exp_v[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_v[1 + i] = b[i];
        if (p_pen(k) != 0) exp_v[9] = (^b) ^ p_podd(k);
        got_v    = '1;
        glitch   = 0;
        ndone    = 0;
        done_pos = -1;
        nbusy    = 0;
        abort    = 1'b0;
        for (int j = 0; j < nb && !abort; j++) begin
          for (int c = 0; c < Cpb && !abort; c++) begin
            if (j != 0 || c != 0) @(negedge clk);
            if (!rst_n) begin
              abort = 1'b1;
            end else begin
              if (c == 0) got_v[j] = tx_w[k];
              else if (tx_w[k] !== got_v[j]) glitch++;
              if (done_w[k]) begin
                ndone++;
                done_pos = j * Cpb + c;
              end
              if (!busy_w[k]) nbusy++;
            end
          end
        end
        if (abort) begin
          b2b = 1'b0;
        end else begin
          check("frame_bits", k, 64'(got_v), 64'(exp_v));
          check("bit_stable", k, 64'(glitch), 64'd0);
          check("tx_done_count", k, 64'(ndone), 64'd1);
          check("tx_done_pos", k, 64'(done_pos), 64'(nb * Cpb - 1));
          check("busy_in_frame", k, 64'(nbusy), 64'd0);
          check("read_to_start", k, 64'(start - rd_cyc[k]), 64'(p_lat(k) + 1));
          if (b2b) check("b2b_gap", k, 64'(start - done_cyc), 64'(p_lat(k) + 2));
          done_cyc = cyc;
          b2b      = enable && ne[k];
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);
  initial monitor(3);

  // READ must never be issued against an empty FIFO.
  initial begin
    forever begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        if (rst_n && rd_w[g]) check("read_nonempty", g, 64'(ne[g]), 64'd1);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exq0.size() + exq1.size() + exq2.size() + exq3.size() != 0 || busy_w != 4'h0)
           && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain_in_budget", 0, 64'(n < budget), 64'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_tx_low(input int k, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx_w[k] && n < budget);
    check("start_seen", k, 64'(!tx_w[k]), 64'd1);
  endtask

  function automatic int total_reads();
    return rd_count[0] + rd_count[1] + rd_count[2] + rd_count[3];
  endfunction

  initial begin
    int rc;
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", 0, 64'(tx_w), 64'hF);
    check("rst_read", 0, 64'(rd_w), 64'h0);
    check("rst_busy", 0, 64'(busy_w), 64'h0);
    check("rst_done", 0, 64'(done_w), 64'h0);
    rst_n = 1'b1;

    // Reset in the middle of the data bits.
    push(0, 8'h3C);
    enable = 1'b1;
    wait_tx_low(0, 20);
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_tx", 0, 64'(tx_w), 64'hF);
    check("midrst_read", 0, 64'(rd_w), 64'h0);
    check("midrst_busy", 0, 64'(busy_w), 64'h0);
    check("midrst_done", 0, 64'(done_w), 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rc = total_reads();
    repeat (20) @(posedge clk);
    #1;
    check("postrst_busy", 0, 64'(busy_w), 64'h0);
    check("postrst_reads", 0, 64'(total_reads()), 64'(rc));

    // 0xA5 on every instance: plain, even parity, odd parity, slow read with 2 stop bits.
    push(0, 8'hA5);
    push(1, 8'hA5);
    push(2, 8'hA5);
    push(3, 8'hA5);
    wait_drain(300);

    // Back-to-back frames.
    push(0, 8'h00);
    push(0, 8'hFF);
    push(3, 8'h81);
    push(3, 8'h7E);
    push(2, 8'hC3);
    push(2, 8'h01);
    wait_drain(400);

    // Empty FIFO with ENABLE high, then data with ENABLE low: no READ either way.
    rc = total_reads();
    repeat (100) @(posedge clk);
    #1;
    check("no_read_empty", 0, 64'(total_reads()), 64'(rc));
    enable = 1'b0;
    push(0, 8'h5A);
    push(1, 8'h3B);
    repeat (40) @(posedge clk);
    #1;
    check("no_read_disabled", 0, 64'(total_reads()), 64'(rc));
    check("idle_disabled_busy", 0, 64'(busy_w), 64'h0);
    enable = 1'b1;
    wait_drain(200);

    // ENABLE dropped during START with three bytes queued.
    rc = rd_count[0];
    push(0, 8'h11);
    push(0, 8'h22);
    push(0, 8'h33);
    wait_tx_low(0, 20);
    @(posedge clk);
    #1 enable = 1'b0;
    begin
      int n;
      n = 0;
      while (busy_w[0] && n < 100) begin
        @(posedge clk);
        n++;
      end
      check("stop_busy_low", 0, 64'(n < 100), 64'd1);
    end
    repeat (10) @(posedge clk);
    #1;
    check("stop_busy", 0, 64'(busy_w[0]), 64'd0);
    check("stop_fifo_left", 0, 64'(wp[0] - rp[0]), 64'd2);
    check("stop_exp_left", 0, 64'(exq0.size()), 64'd2);
    check("stop_reads", 0, 64'(rd_count[0]), 64'(rc + 1));
    enable = 1'b1;
    wait_drain(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
